atpg_vector_sequencer: RTL
==========================

ATPG_VECTOR_SEQUENCER -- requirements
Module: atpg_vector_sequencer

Interface
REQ-001 Parameter VEC_W, default 233, SHALL set the stimulus width driven to the combinational circuit under test (CUT).
REQ-002 Parameter RESP_W, default 140, SHALL set the CUT response width.
REQ-003 Parameter DEPTH, default 16, SHALL set the vector buffer entries; IDX_W = clog2(DEPTH), CNT_W = clog2(DEPTH+1).
REQ-004 Parameter SETTLE, default 2, range 1..255, SHALL set the CUT settle time in clock cycles.
REQ-005 Ports SHALL be:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- wr_en  in  1  vector write strobe.
- wr_data  in  VEC_W  vector to append.
- wr_ready  out  1  buffer accepts writes.
- clear  in  1  empty the buffer.
- start  in  1  begin a test run.
- abort  in  1  cancel the run.
- cut_in  out  VEC_W  stimulus to the CUT.
- cut_out  in  RESP_W  CUT response.
- resp_valid  out  1  captured response available.
- resp_ready  in  1  consumer accepts the response.
- resp_data  out  RESP_W  captured response.
- resp_idx  out  IDX_W  vector index of resp_data.
- vec_count  out  CNT_W  vectors held.
- busy  out  1  state not IDLE.
- done  out  1  one-cycle run-complete pulse.
- sig  out  32  response signature.

Function
REQ-006 The FSM SHALL have states IDLE, APPLY, SETTLE, CAPTURE, OUTPUT and DONE.
REQ-007 wr_ready SHALL equal (state==IDLE && vec_count<DEPTH); a write SHALL be accepted only when wr_en && wr_ready, storing to entry vec_count and incrementing vec_count.
REQ-008 In IDLE, clear SHALL set vec_count to 0 next cycle and take priority over a simultaneous write or start; outside IDLE, clear SHALL be ignored.
REQ-009 start SHALL be accepted only in IDLE with vec_count>0 and no clear: it SHALL set idx to 0 and move to APPLY; otherwise it SHALL be ignored.
REQ-010 APPLY SHALL register cut_in <= mem[idx], load the settle counter with SETTLE, and move to SETTLE.
REQ-011 SETTLE SHALL last exactly SETTLE cycles, then move to CAPTURE.
REQ-012 CAPTURE SHALL register resp_data <= cut_out, set resp_idx <= idx and resp_valid <= 1, then move to OUTPUT.
REQ-013 In OUTPUT, resp_valid, resp_data and resp_idx SHALL hold until resp_valid && resp_ready; on that handshake resp_valid SHALL clear. The FSM SHALL move to DONE if idx == vec_count-1, otherwise increment idx and move to APPLY.
REQ-014 For a start accepted in cycle T with resp_ready held high, resp_valid SHALL first assert in cycle T+SETTLE+3, and each later vector SHALL take SETTLE+3 cycles.
REQ-015 DONE SHALL assert done for exactly one cycle and then return to IDLE; vec_count and buffer contents SHALL be retained.
REQ-016 cut_in SHALL hold the last applied vector between runs.
REQ-017 abort in any non-IDLE state SHALL force IDLE next cycle and clear resp_valid and cut_in; it SHALL NOT assert done. abort SHALL take priority over every handshake in the same cycle and SHALL be ignored in IDLE.
REQ-018 busy SHALL be 1 in every state except IDLE.

Reset
REQ-019 When rst_n is low, the block SHALL asynchronously force state=IDLE, vec_count=0, idx=0, cut_in=0, resp_valid=0, resp_data=0, resp_idx=0, done=0, busy=0 and sig=0; buffer contents SHALL be undefined after reset.

Configuration
REQ-020 With macro ATPG_SIG_MISR_EN defined, sig SHALL be cleared on an accepted start and updated in each CAPTURE cycle as sig <= {sig[30:0], fb} ^ fold, where fb = sig[31]^sig[21]^sig[1]^sig[0] and fold is the XOR of the 32-bit chunks of cut_out, zero-padded at the MSB end. sig SHALL hold when no CAPTURE occurs.
REQ-021 Without ATPG_SIG_MISR_EN, sig SHALL be tied to 0 and no MISR logic SHALL be present; the port list SHALL be identical in both builds.

Verification
REQ-022 Reset with buffer loaded: pulse rst_n low mid-SETTLE -> all outputs 0 immediately, state IDLE, vec_count=0.
REQ-023 Load 3 vectors, start at cycle T, SETTLE=2, resp_ready=1, CUT modelled as cut_out=cut_in[139:0] -> resp_valid at T+5, T+10, T+15 with resp_idx 0,1,2, matching data; done pulses at T+16.
REQ-024 Write DEPTH=16 vectors -> wr_ready low after the 16th; a 17th wr_en is dropped and vec_count stays 16; clear -> vec_count 0 and wr_ready high.
REQ-025 Hold resp_ready low 7 cycles at vector 1 -> resp_valid, resp_data and resp_idx=1 stable throughout; no APPLY of vector 2 until the handshake.
REQ-026 Assert abort in the same cycle as a resp handshake -> IDLE next cycle, resp_valid=0, cut_in=0, done never asserted; start with vec_count=0 -> ignored, busy stays 0.
REQ-027 With ATPG_SIG_MISR_EN defined, run 2 vectors with all-ones responses -> sig equals the golden model value; a rerun gives an identical sig. Without the macro, sig = 0 throughout.

Source files
------------

// File: rtl/atpg_vector_sequencer.sv
// ATPG vector sequencer: buffers test vectors, applies each one to a
// combinational CUT, waits a settle time, captures the response and hands
// it to a consumer over a valid/ready handshake.
// Optional feature: define ATPG_SIG_MISR_EN to compact the captured
// responses into a 32-bit MISR signature on `sig`; otherwise `sig` is 0.
module atpg_vector_sequencer #(
  parameter int unsigned VEC_W  = 233,
  parameter int unsigned RESP_W = 140,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned SETTLE = 2,
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [VEC_W-1:0]  wr_data,
  output logic              wr_ready,
  input  logic              clear,
  input  logic              start,
  input  logic              abort,
  output logic [VEC_W-1:0]  cut_in,
  input  logic [RESP_W-1:0] cut_out,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [RESP_W-1:0] resp_data,
  output logic [IDX_W-1:0]  resp_idx,
  output logic [CNT_W-1:0]  vec_count,
  output logic              busy,
  output logic              done,
  output logic [31:0]       sig
);

  localparam int unsigned ST_W = 3;
  localparam logic [ST_W-1:0] S_IDLE    = 3'd0;
  localparam logic [ST_W-1:0] S_APPLY   = 3'd1;
  localparam logic [ST_W-1:0] S_SETTLE  = 3'd2;
  localparam logic [ST_W-1:0] S_CAPTURE = 3'd3;
  localparam logic [ST_W-1:0] S_OUTPUT  = 3'd4;
  localparam logic [ST_W-1:0] S_DONE    = 3'd5;

  localparam int unsigned SCNT_W = 8;

  logic [VEC_W-1:0]  mem [DEPTH];
  logic [ST_W-1:0]   state, state_d;
  logic [IDX_W-1:0]  idx, idx_d;
  logic [SCNT_W-1:0] settle_cnt, settle_cnt_d;
  logic [CNT_W-1:0]  count_d;
  logic [VEC_W-1:0]  cut_in_d;
  logic              resp_valid_d;
  logic [RESP_W-1:0] resp_data_d;
  logic [IDX_W-1:0]  resp_idx_d;
  logic              done_d;
  logic              wr_fire_c;
  logic              start_fire_c;
  logic              capture_fire_c;

  // Next-state and next-output logic; abort overrides everything outside IDLE
  always_comb begin
    state_d        = state;
    idx_d          = idx;
    settle_cnt_d   = settle_cnt;
    count_d        = vec_count;
    cut_in_d       = cut_in;
    resp_valid_d   = resp_valid;
    resp_data_d    = resp_data;
    resp_idx_d     = resp_idx;
    done_d         = 1'b0;
    wr_fire_c      = 1'b0;
    start_fire_c   = 1'b0;
    capture_fire_c = 1'b0;

    case (state)
      S_IDLE: begin
        if (clear) begin
          count_d = '0;
        end else begin
          if (wr_en && wr_ready) begin
            wr_fire_c = 1'b1;
            count_d   = vec_count + CNT_W'(1);
          end
          if (start && (vec_count != '0)) begin
            start_fire_c = 1'b1;
            idx_d        = '0;
            state_d      = S_APPLY;
          end
        end
      end
      S_APPLY: begin
        cut_in_d     = mem[idx];
        settle_cnt_d = SCNT_W'(SETTLE);
        state_d      = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_cnt <= SCNT_W'(1)) begin
          state_d = S_CAPTURE;
        end else begin
          settle_cnt_d = settle_cnt - SCNT_W'(1);
        end
      end
      S_CAPTURE: begin
        resp_data_d    = cut_out;
        resp_idx_d     = idx;
        resp_valid_d   = 1'b1;
        capture_fire_c = 1'b1;
        state_d        = S_OUTPUT;
      end
      S_OUTPUT: begin
        if (resp_valid && resp_ready) begin
          resp_valid_d = 1'b0;
          if (CNT_W'(idx) == (vec_count - CNT_W'(1))) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            idx_d   = idx + IDX_W'(1);
            state_d = S_APPLY;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort && (state != S_IDLE)) begin
      state_d        = S_IDLE;
      idx_d          = idx;
      resp_valid_d   = 1'b0;
      resp_data_d    = resp_data;
      resp_idx_d     = resp_idx;
      cut_in_d       = '0;
      done_d         = 1'b0;
      capture_fire_c = 1'b0;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      idx        <= '0;
      settle_cnt <= '0;
      vec_count  <= '0;
      cut_in     <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_idx   <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
      wr_ready   <= 1'b1;
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      settle_cnt <= settle_cnt_d;
      vec_count  <= count_d;
      cut_in     <= cut_in_d;
      resp_valid <= resp_valid_d;
      resp_data  <= resp_data_d;
      resp_idx   <= resp_idx_d;
      done       <= done_d;
      busy       <= (state_d != S_IDLE);
      wr_ready   <= (state_d == S_IDLE) && (count_d < CNT_W'(DEPTH));
    end
  end

  // Vector buffer; contents deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_fire_c) begin
      mem[IDX_W'(vec_count)] <= wr_data;
    end
  end

`ifdef ATPG_SIG_MISR_EN
  localparam int unsigned NCHUNK = (RESP_W + 31) / 32;
  localparam int unsigned PAD_W  = NCHUNK * 32;

  logic [PAD_W-1:0] resp_pad_c;
  logic [31:0]      fold_c;
  logic             fb_c;

  // Fold the response into 32 bits by XOR of zero-padded chunks
  always_comb begin
    resp_pad_c = PAD_W'(cut_out);
    fold_c     = '0;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      fold_c = fold_c ^ resp_pad_c[i*32 +: 32];
    end
    fb_c = sig[31] ^ sig[21] ^ sig[1] ^ sig[0];
  end

  // MISR: cleared on run start, advanced once per capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (start_fire_c) begin
      sig <= '0;
    end else if (capture_fire_c) begin
      sig <= {sig[30:0], fb_c} ^ fold_c;
    end
  end
`else
  // Signature disabled
  assign sig = 32'd0;
`endif

endmodule
